// File: rtl/timer_key_ctrl.sv
// Key debounce and start/pause/done control for the 0-59 s seconds timer.
// Define AUTO_RESTART_EN to make RUN wrap on full_count instead of entering DONE.
module timer_key_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_run_n,
   input  logic       key_clr_n,
   input  logic       full_count,
   output logic       ena,
   output logic       tmr_clr,
   output logic [1:0] state,
   output logic       done_led
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   logic [1:0] key_n;
   logic [1:0] press_evt;
   logic       run_evt;
   logic       clr_evt;

   assign key_n = {key_clr_n, key_run_n};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_deb
         logic             s1_reg;
         logic             s2_reg;
         logic             stable_reg;
         logic             stable_d_reg;
         logic             evt_reg;
         logic [CNT_W-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               s1_reg       <= 1'b1;
               s2_reg       <= 1'b1;
               stable_reg   <= 1'b1;
               stable_d_reg <= 1'b1;
               evt_reg      <= 1'b0;
               cnt_reg      <= '0;
            end else begin
               s1_reg       <= key_n[gi];
               s2_reg       <= s1_reg;
               stable_d_reg <= stable_reg;
               // Event only on the released->pressed edge of the accepted level
               evt_reg      <= stable_d_reg & ~stable_reg;
               if (s2_reg == stable_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  stable_reg <= s2_reg;
                  cnt_reg    <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
         end

         assign press_evt[gi] = evt_reg;
      end
   endgenerate

   assign run_evt = press_evt[0];
   assign clr_evt = press_evt[1];

   state_t state_reg;
   logic   ena_reg;
   logic   tmr_clr_reg;
   logic   done_reg;
   logic   mask_reg;
   logic   full_eff;

   // A stale full flag must not act during a clear pulse or the cycle after it
   assign full_eff = full_count & ~tmr_clr_reg & ~mask_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         ena_reg     <= 1'b0;
         tmr_clr_reg <= 1'b0;
         done_reg    <= 1'b0;
         mask_reg    <= 1'b0;
      end else begin
         tmr_clr_reg <= 1'b0;
         mask_reg    <= tmr_clr_reg;
         if (clr_evt) begin
            state_reg   <= ST_IDLE;
            ena_reg     <= 1'b0;
            done_reg    <= 1'b0;
            tmr_clr_reg <= 1'b1;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (run_evt) begin
                     state_reg <= ST_RUN;
                     ena_reg   <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (full_eff) begin
`ifdef AUTO_RESTART_EN
                     tmr_clr_reg <= 1'b1;
`else
                     state_reg <= ST_DONE;
                     ena_reg   <= 1'b0;
                     done_reg  <= 1'b1;
`endif
                  end else if (run_evt) begin
                     state_reg <= ST_PAUSE;
                     ena_reg   <= 1'b0;
                  end
               end
               ST_PAUSE: begin
                  if (run_evt) begin
                     state_reg <= ST_RUN;
                     ena_reg   <= 1'b1;
                  end
               end
               ST_DONE: begin
                  if (run_evt) begin
                     state_reg   <= ST_RUN;
                     ena_reg     <= 1'b1;
                     done_reg    <= 1'b0;
                     tmr_clr_reg <= 1'b1;
                  end
               end
               default: begin
                  state_reg <= ST_IDLE;
                  ena_reg   <= 1'b0;
                  done_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign state    = state_reg;
   assign ena      = ena_reg;
   assign tmr_clr  = tmr_clr_reg;
   assign done_led = done_reg;

endmodule

// File: tb/tb_timer_key_ctrl.sv
// Scoreboard bench for timer_key_ctrl: reference model predicts every output change,
// a monitor compares each observed output transaction against the predicted queue.
module tb_timer_key_ctrl;
   localparam int DEB = 4;
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_run_n = 1'b1;
   logic       key_clr_n = 1'b1;
   logic       full_count = 1'b0;
   logic       ena;
   logic       tmr_clr;
   logic [1:0] state;
   logic       done_led;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic [4:0] vec;
   } exp_t;

   exp_t exp_q[$];
   int   run_q[$];
   int   clr_q[$];

   always #5 clk = ~clk;

   timer_key_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key_run_n(key_run_n),
      .key_clr_n(key_clr_n),
      .full_count(full_count),
      .ena(ena),
      .tmr_clr(tmr_clr),
      .state(state),
      .done_led(done_led)
   );

   // Reference model: a key counts as pressed once it has been sampled low on DEB
   // consecutive edges; the control reacts 4 edges after that last sample.
   initial begin : model
      logic [1:0] k;
      logic [1:0] acc;
      int         len [2];
      logic [1:0] st;
      int         last_clr;
      logic       run_ev, clr_ev, full_eff, clr;
      logic [4:0] vec;
      logic [4:0] prev;
      exp_t       e;
      prev = '0;
      acc = 2'b11;
      st = S_IDLE;
      last_clr = -100;
      len[0] = 0;
      len[1] = 0;
      forever begin
         @(posedge clk);
         cyc++;
         clr = 1'b0;
         if (rst) begin
            acc = 2'b11;
            len[0] = 0;
            len[1] = 0;
            run_q.delete();
            clr_q.delete();
            st = S_IDLE;
            last_clr = -100;
         end else begin
            k = {key_clr_n, key_run_n};
            for (int i = 0; i < 2; i++) begin
               if (k[i] != acc[i]) begin
                  len[i]++;
                  if (len[i] == DEB) begin
                     acc[i] = k[i];
                     len[i] = 0;
                     if (!k[i]) begin
                        if (i == 0) run_q.push_back(cyc + 4);
                        else        clr_q.push_back(cyc + 4);
                     end
                  end
               end else begin
                  len[i] = 0;
               end
            end
            run_ev = (run_q.size() > 0) && (run_q[0] == cyc);
            if (run_ev) void'(run_q.pop_front());
            clr_ev = (clr_q.size() > 0) && (clr_q[0] == cyc);
            if (clr_ev) void'(clr_q.pop_front());
            full_eff = full_count && (cyc > last_clr + 2);
            if (clr_ev) begin
               st = S_IDLE;
               clr = 1'b1;
            end else if (st == S_IDLE) begin
               if (run_ev) st = S_RUN;
            end else if (st == S_RUN) begin
               if (full_eff) begin
`ifdef AUTO_RESTART_EN
                  clr = 1'b1;
`else
                  st = S_DONE;
`endif
               end else if (run_ev) begin
                  st = S_PAUSE;
               end
            end else if (st == S_PAUSE) begin
               if (run_ev) st = S_RUN;
            end else begin
               if (run_ev) begin
                  st = S_RUN;
                  clr = 1'b1;
               end
            end
            if (clr) last_clr = cyc;
         end
         vec = {st, st == S_RUN, clr, st == S_DONE};
         if (vec != prev || clr) begin
            e.cyc = cyc;
            e.vec = vec;
            exp_q.push_back(e);
         end
         prev = vec;
      end
   end

   initial begin : monitor
      logic [4:0] cur;
      logic [4:0] prev;
      exp_t       e;
      prev = '0;
      forever begin
         @(posedge clk);
         #1;
         cur = {state, ena, tmr_clr, done_led};
         if (cur !== prev || tmr_clr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_txn cyc=%0d actual=%b required=none", cyc, cur);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.vec !== cur) begin
                  errors++;
                  $display("FAIL output_txn cyc=%0d actual=%b required=%b@cyc%0d",
                           cyc, cur, e.vec, e.cyc);
               end else begin
                  $display("txn cyc=%0d state=%0d ena=%0b clr=%0b done=%0b ok",
                           cyc, state, ena, tmr_clr, done_led);
               end
            end
         end
         prev = cur;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
      end
   endtask

   task automatic press(input bit clr_key, input int hold);
      if (clr_key) key_clr_n = 1'b0;
      else         key_run_n = 1'b0;
      tick(hold);
      key_clr_n = 1'b1;
      key_run_n = 1'b1;
      tick(DEB + 6);
   endtask

   initial begin : stim
      tick(2);
      check("reset_state", state, S_IDLE);
      check("reset_ena", 2'(ena), 2'd0);
      check("reset_clr", 2'(tmr_clr), 2'd0);
      check("reset_done", 2'(done_led), 2'd0);
      rst = 1'b0;

      // Latency: key low from edge 10, state changes at edge 17
      tick(7);
      key_run_n = 1'b0;
      tick(7);
      check("latency_before", state, S_IDLE);
      tick(1);
      check("latency_state", state, S_RUN);
      check("latency_ena", 2'(ena), 2'd1);
      key_run_n = 1'b1;
      tick(DEB + 6);
      press(1'b1, 6);
      check("clr_to_idle", state, S_IDLE);

      // Glitches shorter than the debounce window
      repeat (10) begin
         key_run_n = 1'b0;
         tick(3);
         key_run_n = 1'b1;
         tick(3);
      end
      tick(DEB + 6);
      check("glitch_state", state, S_IDLE);
      check("glitch_ena", 2'(ena), 2'd0);

      // Run / pause / long hold
      press(1'b0, 6);
      check("run_state", state, S_RUN);
      press(1'b0, 6);
      check("pause_state", state, S_PAUSE);
      check("pause_ena", 2'(ena), 2'd0);
      press(1'b0, 100);
      check("long_hold_state", state, S_RUN);

      // full_count in the same cycle as run_evt, then restart from DONE
      key_run_n = 1'b0;
      tick(7);
      full_count = 1'b1;
      tick(1);
`ifndef AUTO_RESTART_EN
      check("full_prio_state", state, S_DONE);
      check("full_prio_led", 2'(done_led), 2'd1);
      check("full_prio_ena", 2'(ena), 2'd0);
`endif
      key_run_n = 1'b1;
      tick(DEB + 6);
      key_run_n = 1'b0;
      tick(8);
`ifndef AUTO_RESTART_EN
      check("restart_clr", 2'(tmr_clr), 2'd1);
      check("restart_state", state, S_RUN);
`endif
      tick(1);
      check("restart_clr_width", 2'(tmr_clr), 2'd0);
      tick(1);
      full_count = 1'b0;
`ifndef AUTO_RESTART_EN
      check("mask_state", state, S_RUN);
`endif
      key_run_n = 1'b1;
      tick(DEB + 6);

      // Simultaneous run and clear presses
      press(1'b0, 6);
      key_run_n = 1'b0;
      key_clr_n = 1'b0;
      tick(8);
      check("both_state", state, S_IDLE);
      check("both_clr", 2'(tmr_clr), 2'd1);
      check("both_ena", 2'(ena), 2'd0);
      key_run_n = 1'b1;
      key_clr_n = 1'b1;
      tick(DEB + 6);

      // Terminal count while running
      press(1'b0, 6);
      repeat (3) begin
         full_count = 1'b1;
         tick(1);
`ifdef AUTO_RESTART_EN
         check("auto_clr", 2'(tmr_clr), 2'd1);
         check("auto_state", state, S_RUN);
         check("auto_ena", 2'(ena), 2'd1);
         check("auto_led", 2'(done_led), 2'd0);
`endif
         full_count = 1'b0;
         tick(4);
      end
`ifndef AUTO_RESTART_EN
      check("term_state", state, S_DONE);
      check("term_led", 2'(done_led), 2'd1);
`endif
      press(1'b1, 6);

      // Randomized key, flag and occasional reset activity
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 5) == 0)  key_run_n = ~key_run_n;
         if ($urandom_range(0, 15) == 0) key_clr_n = ~key_clr_n;
         if ($urandom_range(0, 9) == 0)  full_count = ~full_count;
         rst = ($urandom_range(0, 499) == 0);
         tick(1);
      end
      rst = 1'b0;
      key_run_n = 1'b1;
      key_clr_n = 1'b1;
      full_count = 1'b0;
      tick(20);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_txn actual=0 required=%0d pending", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
